// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC sequencer that feeds the 3-bit
// Booth multiplier: FSM state encoding, default widths, sign extension.
package mac_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        ARRANQUE,
        ESPERA,
        ACUMULA
    } estado_t;

    localparam int ANCHO_OP_DEF  = 3;
    localparam int ANCHO_ACC_DEF = 10;

    // Product sign extension for the default widths.
    function automatic logic [ANCHO_ACC_DEF-1:0] sext_producto(
        input logic [2*ANCHO_OP_DEF-1:0] p
    );
        return ANCHO_ACC_DEF'($signed(p));
    endfunction

endpackage

// File: rtl/acumulador_mac.sv
// Signed accumulator for the MAC sequencer: sign-extends the product,
// adds it to the running sum and flags two's-complement overflow.
// Ports: clk, reset (sync, active-high), carga_primero (load first term),
//   suma (add term), producto (2*ANCHO_OP), acumulado (ANCHO_ACC), desborde.
module acumulador_mac
    import mac_pkg::*;
#(
    parameter int ANCHO_OP  = ANCHO_OP_DEF,
    parameter int ANCHO_ACC = ANCHO_ACC_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  carga_primero,
    input  logic                  suma,
    input  logic [2*ANCHO_OP-1:0] producto,
    output logic [ANCHO_ACC-1:0]  acumulado,
    output logic                  desborde
);

    localparam int MSB = ANCHO_ACC - 1;

    logic [ANCHO_ACC-1:0] acc_q, acc_d;
    logic                 desb_q, desb_d;
    logic [ANCHO_ACC-1:0] extendido;
    logic [ANCHO_ACC-1:0] suma_w;
    logic                 ov;

    assign extendido = ANCHO_ACC'($signed(producto));
    assign suma_w    = acc_q + extendido;

    // Same-sign addends producing a result of the other sign.
    assign ov = (acc_q[MSB] == extendido[MSB]) &&
                (suma_w[MSB] != acc_q[MSB]);

    always_comb begin
        acc_d  = acc_q;
        desb_d = desb_q;
        if (carga_primero) begin
            acc_d  = extendido;
            desb_d = 1'b0;
        end else if (suma) begin
            acc_d  = suma_w;
            desb_d = desb_q | ov;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            desb_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            desb_q <= desb_d;
        end
    end

    assign acumulado = acc_q;
    assign desborde  = desb_q;

endmodule

// File: rtl/secuenciador_mac.sv
// MAC front end: accepts signed operand pairs over valid/ready, launches the
// Booth multiplier with a reset pulse, waits for Fin and accumulates.
// Ports: clk, reset; valido_in/listo_out/multiplicando_in/multiplicador_in/
//   ultimo_in (input handshake); mult_* (multiplier side); acumulado,
//   valido_out, desborde, error_to (results).
// Optional: SECUENCIADOR_TIMEOUT_EN adds an ESPERA watchdog driving error_to.
module secuenciador_mac
    import mac_pkg::*;
#(
    parameter int ANCHO_OP       = ANCHO_OP_DEF,
    parameter int ANCHO_ACC      = ANCHO_ACC_DEF,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valido_in,
    output logic                  listo_out,
    input  logic [ANCHO_OP-1:0]   multiplicando_in,
    input  logic [ANCHO_OP-1:0]   multiplicador_in,
    input  logic                  ultimo_in,
    output logic [ANCHO_OP-1:0]   mult_multiplicando,
    output logic [ANCHO_OP-1:0]   mult_multiplicador,
    output logic                  mult_reset,
    input  logic [2*ANCHO_OP-1:0] mult_resultado,
    input  logic                  mult_fin,
    output logic [ANCHO_ACC-1:0]  acumulado,
    output logic                  valido_out,
    output logic                  desborde,
    output logic                  error_to
);

    estado_t             estado_q, estado_d;
    logic [ANCHO_OP-1:0] op_a_q, op_a_d;
    logic [ANCHO_OP-1:0] op_b_q, op_b_d;
    logic                ultimo_q, ultimo_d;
    logic                primero_q, primero_d;
    logic                guarda_q, guarda_d;
    logic                valido_q, valido_d;
    logic                aceptar;
    logic                carga_primero;
    logic                suma;

`ifdef SECUENCIADOR_TIMEOUT_EN
    localparam int ANCHO_CNT = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [ANCHO_CNT-1:0] LIMITE = ANCHO_CNT'(TIMEOUT_CICLOS - 1);

    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    logic                 error_q, error_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CICLOS;
`endif

    assign listo_out  = (estado_q == REPOSO) && !reset;
    assign aceptar    = valido_in && listo_out;
    assign mult_reset = reset || (estado_q == ARRANQUE);

    always_comb begin
        estado_d      = estado_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        ultimo_d      = ultimo_q;
        primero_d     = primero_q;
        guarda_d      = guarda_q;
        valido_d      = 1'b0;
        carga_primero = 1'b0;
        suma          = 1'b0;
`ifdef SECUENCIADOR_TIMEOUT_EN
        cnt_d         = '0;
        error_d       = error_q;
`endif
        unique case (estado_q)
            REPOSO: begin
                if (aceptar) begin
                    op_a_d   = multiplicando_in;
                    op_b_d   = multiplicador_in;
                    ultimo_d = ultimo_in;
                    estado_d = ARRANQUE;
                end
            end
            ARRANQUE: begin
                // Fin may still be high from the previous product.
                guarda_d = 1'b1;
                estado_d = ESPERA;
            end
            ESPERA: begin
                guarda_d = 1'b0;
`ifdef SECUENCIADOR_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (mult_fin && !guarda_q) begin
                    estado_d = ACUMULA;
                end
`ifdef SECUENCIADOR_TIMEOUT_EN
                else if (cnt_q == LIMITE) begin
                    error_d   = 1'b1;
                    primero_d = 1'b1;
                    estado_d  = REPOSO;
                end
`endif
            end
            ACUMULA: begin
                carga_primero = primero_q;
                suma          = !primero_q;
                primero_d     = ultimo_q;
                valido_d      = ultimo_q;
                estado_d      = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= REPOSO;
            op_a_q    <= '0;
            op_b_q    <= '0;
            ultimo_q  <= 1'b0;
            primero_q <= 1'b1;
            guarda_q  <= 1'b0;
            valido_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            ultimo_q  <= ultimo_d;
            primero_q <= primero_d;
            guarda_q  <= guarda_d;
            valido_q  <= valido_d;
        end
    end

`ifdef SECUENCIADOR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign error_to = error_q;
`else
    assign error_to = 1'b0;
`endif

    acumulador_mac #(
        .ANCHO_OP  (ANCHO_OP),
        .ANCHO_ACC (ANCHO_ACC)
    ) u_acumulador (
        .clk           (clk),
        .reset         (reset),
        .carga_primero (carga_primero),
        .suma          (suma),
        .producto      (mult_resultado),
        .acumulado     (acumulado),
        .desborde      (desborde)
    );

    assign mult_multiplicando = op_a_q;
    assign mult_multiplicador = op_b_q;
    assign valido_out         = valido_q;

endmodule

// File: tb/tb_secuenciador_mac.sv
// Directed bench for secuenciador_mac with a 4-cycle behavioural multiplier.
// Covers single term, sequences, wrap/overflow, backpressure, reset, timeout.
module tb_secuenciador_mac;

    logic       clk;
    logic       reset;
    logic       valido_in;
    logic       listo_out;
    logic [2:0] multiplicando_in;
    logic [2:0] multiplicador_in;
    logic       ultimo_in;
    logic [2:0] mult_multiplicando;
    logic [2:0] mult_multiplicador;
    logic       mult_reset;
    logic [5:0] mult_resultado;
    logic       mult_fin;
    logic [9:0] acumulado;
    logic       valido_out;
    logic       desborde;
    logic       error_to;

    int checks;
    int errors;
    int n_valido;

    localparam logic [2:0] M4 = 3'b100;
    localparam logic [2:0] M1 = 3'b111;

    secuenciador_mac dut (
        .clk                (clk),
        .reset              (reset),
        .valido_in          (valido_in),
        .listo_out          (listo_out),
        .multiplicando_in   (multiplicando_in),
        .multiplicador_in   (multiplicador_in),
        .ultimo_in          (ultimo_in),
        .mult_multiplicando (mult_multiplicando),
        .mult_multiplicador (mult_multiplicador),
        .mult_reset         (mult_reset),
        .mult_resultado     (mult_resultado),
        .mult_fin           (mult_fin),
        .acumulado          (acumulado),
        .valido_out         (valido_out),
        .desborde           (desborde),
        .error_to           (error_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: Fin rises 4 cycles after reset is released.
    logic [2:0] mod_cnt;
    logic       mod_fin;
    logic       forzar_fin_cero;

    always @(posedge clk) begin
        if (mult_reset) begin
            mod_cnt <= 3'd0;
            mod_fin <= 1'b0;
        end else if (!mod_fin) begin
            if (mod_cnt == 3'd3) begin
                if (!forzar_fin_cero) mod_fin <= 1'b1;
            end else begin
                mod_cnt <= mod_cnt + 3'd1;
            end
        end
    end

    assign mult_fin       = mod_fin;
    assign mult_resultado = {{3{mult_multiplicando[2]}}, mult_multiplicando} *
                            {{3{mult_multiplicador[2]}}, mult_multiplicador};

    always @(posedge clk) begin
        if (valido_out === 1'b1) n_valido <= n_valido + 1;
    end

    task automatic enviar(input logic [2:0] a, input logic [2:0] b,
                          input logic u);
        int k;
        k = 0;
        @(negedge clk);
        while (listo_out !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (listo_out !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL enviar_listo got=%b want=1", listo_out);
        end
        valido_in        = 1'b1;
        multiplicando_in = a;
        multiplicador_in = b;
        ultimo_in        = u;
        @(posedge clk);
        #1;
        valido_in = 1'b0;
    endtask

    task automatic esperar_valido(output int k);
        k = 0;
        @(negedge clk);
        while (valido_out !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (valido_out !== 1'b1) begin
            errors++;
            $display("FAIL esperar_valido got=%b want=1", valido_out);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (listo_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_listo got=%b want=0", listo_out);
        end
        checks++;
        if (mult_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_mult_reset got=%b want=1", mult_reset);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (acumulado !== 10'd0 || desborde !== 1'b0 ||
            valido_out !== 1'b0 || error_to !== 1'b0) begin
            errors++;
            $display("FAIL reset_salidas got=%h/%b/%b/%b want=000/0/0/0",
                     acumulado, desborde, valido_out, error_to);
        end
        checks++;
        if (mult_multiplicando !== 3'd0 || mult_multiplicador !== 3'd0) begin
            errors++;
            $display("FAIL reset_ops got=%h/%h want=0/0",
                     mult_multiplicando, mult_multiplicador);
        end
        checks++;
        if (listo_out !== 1'b1 || mult_reset !== 1'b0) begin
            errors++;
            $display("FAIL reset_listo_post got=%b/%b want=1/0",
                     listo_out, mult_reset);
        end
    endtask

    task automatic test_uno();
        int n0;
        int k;
        n0 = n_valido;
        enviar(3'd3, 3'd2, 1'b1);
        @(negedge clk);
        checks++;
        if (mult_reset !== 1'b1 || listo_out !== 1'b0) begin
            errors++;
            $display("FAIL uno_arranque got=%b/%b want=1/0",
                     mult_reset, listo_out);
        end
        esperar_valido(k);
        checks++;
        if (k != 6) begin
            errors++;
            $display("FAIL uno_latencia got=%0d want=6", k);
        end
        checks++;
        if (acumulado !== 10'd6 || desborde !== 1'b0) begin
            errors++;
            $display("FAIL uno_acum got=%h/%b want=006/0", acumulado, desborde);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (valido_out !== 1'b0 || n_valido - n0 != 1) begin
            errors++;
            $display("FAIL uno_pulso got=%b/%0d want=0/1",
                     valido_out, n_valido - n0);
        end
        checks++;
        if (acumulado !== 10'd6 || listo_out !== 1'b1) begin
            errors++;
            $display("FAIL uno_hold got=%h/%b want=006/1", acumulado, listo_out);
        end
    endtask

    task automatic test_secuencia();
        int n0;
        int k;
        n0 = n_valido;
        enviar(3'd3, 3'd2, 1'b0);
        enviar(M4, 3'd3, 1'b0);
        enviar(3'd1, M1, 1'b1);
        esperar_valido(k);
        checks++;
        if (acumulado !== 10'h3F9 || desborde !== 1'b0) begin
            errors++;
            $display("FAIL secuencia_acum got=%h/%b want=3f9/0",
                     acumulado, desborde);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_valido - n0 != 1) begin
            errors++;
            $display("FAIL secuencia_pulsos got=%0d want=1", n_valido - n0);
        end
    endtask

    task automatic test_desborde();
        int n0;
        int k;
        n0 = n_valido;
        for (int i = 0; i < 32; i++) begin
            enviar(M4, M4, (i == 31));
        end
        esperar_valido(k);
        checks++;
        if (acumulado !== 10'h200 || desborde !== 1'b1) begin
            errors++;
            $display("FAIL desborde_wrap got=%h/%b want=200/1",
                     acumulado, desborde);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_valido - n0 != 1 || desborde !== 1'b1) begin
            errors++;
            $display("FAIL desborde_sticky got=%0d/%b want=1/1",
                     n_valido - n0, desborde);
        end
        enviar(3'd1, 3'd1, 1'b1);
        esperar_valido(k);
        checks++;
        if (acumulado !== 10'd1 || desborde !== 1'b0) begin
            errors++;
            $display("FAIL desborde_limpia got=%h/%b want=001/0",
                     acumulado, desborde);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        valido_in        = 1'b1;
        multiplicando_in = 3'd1;
        multiplicador_in = 3'd2;
        ultimo_in        = 1'b1;
        @(posedge clk);
        #1;
        multiplicando_in = 3'd3;
        multiplicador_in = 3'd3;
        repeat (3) @(negedge clk);
        checks++;
        if (listo_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_listo got=%b want=0", listo_out);
        end
        checks++;
        if (mult_multiplicando !== 3'd1 || mult_multiplicador !== 3'd2) begin
            errors++;
            $display("FAIL bp_ops got=%h/%h want=1/2",
                     mult_multiplicando, mult_multiplicador);
        end
        esperar_valido(k);
        checks++;
        if (acumulado !== 10'd2) begin
            errors++;
            $display("FAIL bp_primero got=%h want=002", acumulado);
        end
        @(posedge clk);
        #1;
        valido_in = 1'b0;
        @(negedge clk);
        checks++;
        if (mult_multiplicando !== 3'd3 || mult_multiplicador !== 3'd3) begin
            errors++;
            $display("FAIL bp_ops2 got=%h/%h want=3/3",
                     mult_multiplicando, mult_multiplicador);
        end
        esperar_valido(k);
        checks++;
        if (acumulado !== 10'd9) begin
            errors++;
            $display("FAIL bp_segundo got=%h want=009", acumulado);
        end
    endtask

    task automatic test_reset_medio();
        int n0;
        int k;
        enviar(3'd2, 3'd2, 1'b0);
        enviar(3'd1, 3'd1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mult_reset !== 1'b1 || listo_out !== 1'b0) begin
            errors++;
            $display("FAIL rm_durante got=%b/%b want=1/0",
                     mult_reset, listo_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        n0 = n_valido;
        @(negedge clk);
        checks++;
        if (acumulado !== 10'd0 || desborde !== 1'b0 ||
            mult_multiplicando !== 3'd0 || mult_multiplicador !== 3'd0 ||
            valido_out !== 1'b0 || listo_out !== 1'b1) begin
            errors++;
            $display("FAIL rm_valores got=%h/%b/%h/%h/%b/%b want=000/0/0/0/0/1",
                     acumulado, desborde, mult_multiplicando,
                     mult_multiplicador, valido_out, listo_out);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (n_valido - n0 != 0) begin
            errors++;
            $display("FAIL rm_sin_valido got=%0d want=0", n_valido - n0);
        end
        enviar(3'd1, 3'd3, 1'b1);
        esperar_valido(k);
        checks++;
        if (acumulado !== 10'd3 || error_to !== 1'b0) begin
            errors++;
            $display("FAIL rm_nuevo got=%h/%b want=003/0", acumulado, error_to);
        end
    endtask

`ifdef SECUENCIADOR_TIMEOUT_EN
    task automatic test_timeout();
        int n0;
        int k;
        n0 = n_valido;
        forzar_fin_cero = 1'b1;
        enviar(3'd2, 3'd3, 1'b1);
        k = 0;
        @(negedge clk);
        while (listo_out !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 17) begin
            errors++;
            $display("FAIL to_ciclos got=%0d want=17", k);
        end
        checks++;
        if (error_to !== 1'b1 || acumulado !== 10'd3) begin
            errors++;
            $display("FAIL to_flag got=%b/%h want=1/003", error_to, acumulado);
        end
        forzar_fin_cero = 1'b0;
        enviar(3'd1, 3'd1, 1'b1);
        esperar_valido(k);
        checks++;
        if (acumulado !== 10'd1 || error_to !== 1'b1 || n_valido - n0 != 0) begin
            errors++;
            $display("FAIL to_sticky got=%h/%b/%0d want=001/1/0",
                     acumulado, error_to, n_valido - n0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (error_to !== 1'b0) begin
            errors++;
            $display("FAIL to_reset got=%b want=0", error_to);
        end
    endtask
`endif

    initial begin
        checks           = 0;
        errors           = 0;
        n_valido         = 0;
        forzar_fin_cero  = 1'b0;
        reset            = 1'b1;
        valido_in        = 1'b0;
        multiplicando_in = 3'd0;
        multiplicador_in = 3'd0;
        ultimo_in        = 1'b0;
        test_reset();
        test_uno();
        test_secuencia();
        test_desborde();
        test_back_to_back();
        test_reset_medio();
`ifdef SECUENCIADOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_mac.md
Name: secuenciador_mac

Overview:
- Upstream/downstream companion of the 3-bit Booth multiplier. It takes signed operand pairs through a valid/ready handshake and drives them into the multiplier.
- It launches each multiplication by pulsing the multiplier's reset, waits for its Fin, then sign-extends and accumulates the 6-bit product.
- Produces a dot-product result per `ultimo_in`-terminated sequence. Used as the MAC front end of the datapath.

Parameters:
- ANCHO_OP, 3, operand width in bits; must match the multiplier.
- ANCHO_ACC, 10, accumulator width in bits, two's complement; must be >= 2*ANCHO_OP.
- TIMEOUT_CICLOS, 16, watchdog limit in cycles (only used with SECUENCIADOR_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- valido_in  in  1  operand pair present
- listo_out  out  1  block accepts a pair this cycle
- multiplicando_in  in  ANCHO_OP  signed operand A
- multiplicador_in  in  ANCHO_OP  signed operand B
- ultimo_in  in  1  pair is the last of a dot product
- mult_multiplicando  out  ANCHO_OP  registered operand A to the multiplier
- mult_multiplicador  out  ANCHO_OP  registered operand B to the multiplier
- mult_reset  out  1  multiplier reset / start pulse
- mult_resultado  in  2*ANCHO_OP  signed product from the multiplier
- mult_fin  in  1  multiplier Fin (stays high until the multiplier is reset)
- acumulado  out  ANCHO_ACC  accumulated dot product, signed
- valido_out  out  1  one-cycle pulse; `acumulado` holds the final sum
- desborde  out  1  overflow flag for the current/last dot product
- error_to  out  1  timeout flag (tied 0 without the macro)

Behaviour:
- Reset is synchronous, active-high, on clk.
  - State goes to REPOSO. acumulado=0, valido_out=0, desborde=0, error_to=0, mult operands=0, primero=1.
  - mult_reset = reset OR (estado==ARRANQUE), so the multiplier is held in reset whenever this block is.
- listo_out = (estado==REPOSO) AND NOT reset, combinational.
- A pair is accepted when valido_in AND listo_out at a clock edge. At acceptance:
  - capture both operands into the mult_* registers and `ultimo_in` into ultimo_r;
  - go to ARRANQUE.
- FSM:
  - REPOSO -> ARRANQUE on accept; otherwise stay.
  - ARRANQUE (1 cycle): mult_reset=1. Go to ESPERA.
  - ESPERA: the first cycle ignores mult_fin (guard bit). After that, mult_fin=1 moves to ACUMULA. mult_* operands stay stable throughout.
  - ACUMULA (1 cycle): update the accumulator, then go to REPOSO.
    - If primero=1: acumulado <= sext(mult_resultado) and desborde <= 0.
    - Otherwise: acumulado <= acumulado + sext(mult_resultado).
    - primero <= ultimo_r.
    - valido_out <= ultimo_r.
- Arithmetic: sign-extend 2*ANCHO_OP bits to ANCHO_ACC bits. The sum wraps modulo 2^ANCHO_ACC.
  - desborde is set when both addends have the same sign and the sum sign differs.
  - desborde is sticky until the first ACUMULA of the next dot product.
- valido_out is high exactly one cycle, coinciding with the return to REPOSO. acumulado holds its value until the next ACUMULA.
- Latency: accept at edge t, so ARRANQUE=t+1 and ESPERA from t+2. valido_out = (fin edge)+2 cycles.
- Backpressure: while not in REPOSO, listo_out=0 and the inputs are ignored. Holding valido_in high is legal.
- Reset mid-operation (any state): immediate return to the reset values. The partial sum is discarded and no valido_out is produced.
- A single pair with ultimo_in=1 is a valid one-term dot product.

Optional Feature:
- Macro: SECUENCIADOR_TIMEOUT_EN.
- Defined:
  - A counter runs in ESPERA. If mult_fin is not seen within TIMEOUT_CICLOS cycles, set error_to (sticky until reset) and go to REPOSO.
  - No accumulation is performed. primero is set to 1, so the sequence is aborted.
- Not defined: ESPERA waits indefinitely, error_to is tied 0, and no counter is synthesised.

Decomposition:
- Package mac_pkg:
  - state enum {REPOSO, ARRANQUE, ESPERA, ACUMULA};
  - default ANCHO_OP and ANCHO_ACC constants;
  - sign-extend function.
- Sub-module acumulador_mac: sign-extension, adder, overflow detection and accumulator/desborde registers, controlled by carga_primero and suma enables.
- The FSM and handshake stay in the top module.

Test Plan:
- Pair (3,2) with ultimo=1, behavioural multiplier model with 4-cycle latency -> mult_reset pulses 1 cycle after accept; valido_out once; acumulado=6; desborde=0.
- Sequence (3,2), (-4,3), (1,-1) with ultimo on the third -> single valido_out; acumulado=-7 (10'h3F9).
- 32 pairs of (-4,-4), last flagged -> acumulado wraps to -512 (10'h200); desborde=1. The next single (1,1) gives acumulado=1, desborde=0.
- valido_in held high while busy, operands changed mid-ESPERA -> listo_out=0, mult_* operands unchanged, changed values not consumed until REPOSO.
- reset asserted 2 cycles into ESPERA of the second pair of a sequence -> all outputs 0 next edge; no valido_out; a new (1,3) with ultimo gives acumulado=3.
- With SECUENCIADOR_TIMEOUT_EN and mult_fin stuck 0 -> error_to=1 after 16 ESPERA cycles; listo_out returns to 1; acumulado unchanged.
